// File: rtl/mips_mcycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with a
// req/ack memory handshake and wait-state timeout. Define MCYCLE_JUMP_EN to decode j (0x02).
module mips_mcycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] aluop,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;

    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_ILLEGAL = 2'd2;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
`ifdef MCYCLE_JUMP_EN
        S_JUMP,
`endif
        S_FAULT
    } state_t;

    // Moore part of the outputs; fetch/branch/jump/wr_retire flag the ack- and zero-qualified ones.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       fetch;
        logic       branch;
        logic       jump;
        logic       wr_retire;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] aluop;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       fault;
    } ctl_t;

    state_t     state, state_nxt;
    logic [1:0] code_q, code_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    ctl_t       ctl_q;
    logic       mem_phase, timed_out;

    function automatic ctl_t ctl_of(input state_t s, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = 2'd1;
                c.aluop     = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'd3;
                c.aluop     = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.aluop     = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_we    = 1'b1;
                c.iord      = 1'b1;
                c.wr_retire = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.aluop     = (fn == F_SLL) ? ALU_SLL : (fn == F_SRL) ? ALU_SRL : ALU_ADD;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.retire    = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.aluop     = ALU_SUB;
                c.pc_src    = 2'd1;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
`ifdef MCYCLE_JUMP_EN
            S_JUMP: begin
                c.pc_src = 2'd2;
                c.jump   = 1'b1;
                c.retire = 1'b1;
            end
`endif
            S_FAULT: c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign mem_phase = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timed_out = (TIMEOUT != 0) && mem_phase && !mem_ack && (cnt == LAST);

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        case (state)
            S_START:  state_nxt = S_FETCH;
            S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    state_nxt = S_MEMADR;
                else if (opcode == OP_ADDI || opcode == OP_ADDIU)
                    state_nxt = S_ADDIEX;
                else if (opcode == OP_BEQ)
                    state_nxt = S_BRANCH;
                else if (opcode == OP_RTYPE && (funct == F_SLL || funct == F_SRL || funct == F_ADD))
                    state_nxt = S_EXEC;
`ifdef MCYCLE_JUMP_EN
                else if (opcode == OP_J)
                    state_nxt = S_JUMP;
`endif
                else begin
                    state_nxt = S_FAULT;
                    code_nxt  = FC_ILLEGAL;
                end
            end
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ack) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (mem_ack) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
`ifdef MCYCLE_JUMP_EN
            S_JUMP:   state_nxt = S_FETCH;
`endif
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_START;
        endcase
        // An ack in the last allowed cycle wins; only a missing ack there faults.
        if (timed_out) begin
            state_nxt = S_FAULT;
            code_nxt  = FC_TIMEOUT;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state &&
            (state_nxt == S_FETCH || state_nxt == S_MEMRD || state_nxt == S_MEMWR))
            cnt_nxt = '0;
        else if (mem_phase && !mem_ack)
            cnt_nxt = cnt + CW'(1);
    end

    // ctl_q tracks ctl_of(state): both are loaded from the same next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_START;
            cnt    <= '0;
            code_q <= '0;
            ctl_q  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            ctl_q  <= ctl_of(state_nxt, funct);
        end
    end

    assign mem_req    = ctl_q.mem_req;
    assign mem_we     = ctl_q.mem_we;
    assign iord       = ctl_q.iord;
    assign ir_write   = ctl_q.fetch & mem_ack;
    assign pc_en      = (ctl_q.fetch & mem_ack) | (ctl_q.branch & zero) | ctl_q.jump;
    assign pc_src     = ctl_q.pc_src;
    assign alu_src_a  = ctl_q.alu_src_a;
    assign alu_src_b  = ctl_q.alu_src_b;
    assign aluop      = ctl_q.aluop;
    assign reg_write  = ctl_q.reg_write;
    assign reg_dst    = ctl_q.reg_dst;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign retire     = ctl_q.retire | (ctl_q.wr_retire & mem_ack);
    assign fault      = ctl_q.fault;
    assign fault_code = code_q;

endmodule

// File: tb/tb_mips_mcycle_ctrl.sv
// Bench for mips_mcycle_ctrl: per-instruction expected cycle sequences built from the
// instruction-level rules, driven with random waits, ack noise and zero flags.
module tb_mips_mcycle_ctrl;

    localparam int TO = 4;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2B;
`ifdef MCYCLE_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_en, alu_src_a;
    logic       reg_write, reg_dst, mem_to_reg, retire, fault;
    logic [1:0] pc_src, alu_src_b, fault_code;
    logic [3:0] aluop;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] aluop;
        logic       reg_write, reg_dst, mem_to_reg, retire, fault;
        logic [1:0] fault_code;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ack;
        outs_t      e;
    } step_t;

    step_t q[$];
    int    total = 0, bad = 0;
    outs_t act;

    assign act = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, aluop,
                  reg_write, reg_dst, mem_to_reg, retire, fault, fault_code};

    mips_mcycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .aluop(aluop), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .retire(retire), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic ack, input outs_t e);
        step_t s;
        s.op = op; s.fn = fn; s.z = z; s.ack = ack; s.e = e;
        q.push_back(s);
    endtask

    // Cycle where the memory port is idle: ack and zero are noise.
    task automatic push_idle(input logic [5:0] op, input logic [5:0] fn, input outs_t e);
        push(op, fn, rb(), rb(), e);
    endtask

    task automatic push_fault(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] code,
                              input int n);
        outs_t e;
        e = '0; e.fault = 1'b1; e.fault_code = code;
        repeat (n) push_idle(op, fn, e);
    endtask

    task automatic push_fwait(input logic [5:0] op, input logic [5:0] fn, input int n);
        outs_t e;
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.aluop = 4'd2;
        repeat (n) push(op, fn, rb(), 1'b0, e);
    endtask

    // Whole-instruction expectation: fw fetch wait cycles, dw data wait cycles.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                              input int dw, input logic bz);
        outs_t e;
        push_fwait(op, fn, fw);
        if (fw >= TO) begin
            push_fault(op, fn, 2'd1, 3);
            return;
        end
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.aluop = 4'd2;
        e.ir_write = 1'b1; e.pc_en = 1'b1;
        push(op, fn, rb(), 1'b1, e);
        e = '0; e.alu_src_b = 2'd3; e.aluop = 4'd2;
        push_idle(op, fn, e);
        if (op == OP_LW || op == OP_SW) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluop = 4'd2;
            push_idle(op, fn, e);
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == OP_SW);
            repeat (dw) push(op, fn, rb(), 1'b0, e);
            if (dw >= TO) begin
                push_fault(op, fn, 2'd1, 3);
                return;
            end
            e.retire = (op == OP_SW);
            push(op, fn, rb(), 1'b1, e);
            if (op == OP_LW) begin
                e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
                push_idle(op, fn, e);
            end
        end else if (op == OP_ADDI || op == OP_ADDIU) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluop = 4'd2;
            push_idle(op, fn, e);
            e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
            push_idle(op, fn, e);
        end else if (op == OP_BEQ) begin
            e = '0; e.alu_src_a = 1'b1; e.aluop = 4'd6; e.pc_src = 2'd1;
            e.pc_en = bz; e.retire = 1'b1;
            push(op, fn, bz, rb(), e);
        end else if (op == OP_R && (fn == 6'h00 || fn == 6'h02 || fn == 6'h20)) begin
            e = '0; e.alu_src_a = 1'b1;
            e.aluop = (fn == 6'h00) ? 4'd3 : (fn == 6'h02) ? 4'd4 : 4'd2;
            push_idle(op, fn, e);
            e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
            push_idle(op, fn, e);
        end else if (op == OP_J && JEN) begin
            e = '0; e.pc_src = 2'd2; e.pc_en = 1'b1; e.retire = 1'b1;
            push_idle(op, fn, e);
        end else begin
            push_fault(op, fn, 2'd2, 3);
        end
    endtask

    task automatic run_q(input string name);
        step_t s;
        int n;
        n = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            opcode = s.op; funct = s.fn; zero = s.z; mem_ack = s.ack;
            @(negedge clk);
            total++;
            if (act !== s.e) begin
                bad++;
                $display("FAIL %s step %0d: got %h expected %h", name, n, act, s.e);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench at posedge+1 with reset just released; the next cycle is START.
    task automatic do_reset(input string name);
        rst_n = 1'b0; mem_ack = 1'b1; zero = 1'b1; opcode = 6'($urandom);
        @(negedge clk);
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL %s reset outputs: got %h expected 0", name, act);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_idle(6'($urandom), 6'($urandom), '0);
    endtask

    task automatic test_reset();
        do_reset("reset");
        push_instr(OP_ADDI, 6'($urandom), 0, 0, 1'b0);
        run_q("reset_addi");
    endtask

    task automatic test_lw_wait();
        do_reset("lw_wait");
        push_instr(OP_LW, 6'($urandom), 0, 3, 1'b0);
        push_instr(OP_SW, 6'($urandom), 1, 2, 1'b0);
        run_q("lw_wait");
    endtask

    task automatic test_rtype();
        do_reset("rtype");
        push_instr(OP_R, 6'h00, 0, 0, 1'b0);
        push_instr(OP_R, 6'h02, 0, 0, 1'b0);
        push_instr(OP_R, 6'h20, 0, 0, 1'b0);
        run_q("rtype");
    endtask

    task automatic test_beq();
        do_reset("beq");
        push_instr(OP_BEQ, 6'($urandom), 0, 0, 1'b1);
        push_instr(OP_BEQ, 6'($urandom), 0, 0, 1'b0);
        run_q("beq");
    endtask

    task automatic test_timeout();
        do_reset("fetch_timeout");
        push_instr(OP_ADDI, 6'($urandom), TO, 0, 1'b0);
        run_q("fetch_timeout");
        do_reset("fetch_last_ack");
        push_instr(OP_ADDIU, 6'($urandom), TO - 1, 0, 1'b0);
        run_q("fetch_last_ack");
        do_reset("data_timeout");
        push_instr(OP_LW, 6'($urandom), 0, TO, 1'b0);
        run_q("data_timeout");
        do_reset("data_last_ack");
        push_instr(OP_SW, 6'($urandom), 0, TO - 1, 1'b0);
        run_q("data_last_ack");
    endtask

    task automatic test_jump();
        do_reset("jump");
        push_instr(OP_J, 6'($urandom), 0, 0, 1'b0);
        run_q("jump");
    endtask

    task automatic test_illegal();
        logic [5:0] ops[6];
        logic [5:0] fns[6];
        ops = '{6'h01, 6'h05, 6'h3F, 6'h0F, OP_R, OP_R};
        fns = '{6'h00, 6'h20, 6'h02, 6'h00, 6'h21, 6'h08};
        for (int i = 0; i < 6; i++) begin
            do_reset("illegal");
            push_instr(ops[i], fns[i], 0, 0, 1'b0);
            run_q("illegal");
        end
    endtask

    task automatic test_midreset();
        do_reset("midreset");
        push_fwait(OP_LW, 6'h00, 2);
        run_q("midreset_fetch");
        mem_ack = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL midreset mem_req before reset: got %b expected 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL midreset async clear: got %h expected 0", act);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] op, fn;
        int k;
        do_reset("back_to_back");
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, JEN ? 8 : 7);
            fn = 6'($urandom);
            case (k)
                0: op = OP_LW;
                1: op = OP_SW;
                2: begin op = OP_R; fn = 6'h00; end
                3: begin op = OP_R; fn = 6'h02; end
                4: begin op = OP_R; fn = 6'h20; end
                5: op = OP_ADDI;
                6: op = OP_ADDIU;
                7: op = OP_BEQ;
                default: op = OP_J;
            endcase
            push_instr(op, fn, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), rb());
        end
        run_q("back_to_back");
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_lw_wait();
        test_rtype();
        test_beq();
        test_timeout();
        test_jump();
        test_illegal();
        test_midreset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mcycle_ctrl.md
# mips_mcycle_ctrl

Multi-cycle control FSM for the MIPS core. It sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and single memory port. It drives the 4-bit ALU operation code directly: 2 = add, 3 = sll, 4 = srl, 6 = subtract/compare. It also runs a req/ack handshake with the memory port, with an optional wait-state timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles a memory request waits for `mem_ack`; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ack  in  1  memory port has completed the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  write request; valid only with `mem_req`.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_en  out  1  load the PC.
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B source: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate<<2.
- aluop  out  4  ALU operation code.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = memory data.
- retire  out  1  1-cycle pulse in the final cycle of each instruction.
- fault  out  1  sticky; set when the FSM is in FAULT.
- fault_code  out  2  1 = memory timeout, 2 = illegal instruction; 0 otherwise.

## Operation
- Moore-style outputs decoded from the state register. Exceptions, which are qualified combinationally:
  - `ir_write` and `pc_en` in FETCH are qualified by `mem_ack`.
  - `pc_en` in BRANCH is qualified by `zero`.
- Every output not listed for a state is 0.
- States and transitions:
  - START: all outputs 0 → FETCH.
  - FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `aluop`=2, `pc_src`=0. On `mem_ack`: `ir_write`=1, `pc_en`=1, → DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=3, `aluop`=2 (branch target into ALUOut). Next state by instruction:
    - lw (0x23) / sw (0x2B) → MEMADR.
    - addi (0x08) / addiu (0x09) → ADDIEX.
    - beq (0x04) → BRANCH.
    - opcode 0x00 with funct 0x00 / 0x02 / 0x20 → EXEC.
    - j (0x02) → JUMP, only when compiled in.
    - Anything else → FAULT, `fault_code`=2.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=2, `aluop`=2. lw → MEMRD; sw → MEMWR.
  - MEMRD: `mem_req`=1, `iord`=1. On `mem_ack` → MEMWB.
  - MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `retire`=1 → FETCH.
  - MEMWR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ack`: `retire`=1, → FETCH.
  - EXEC: `alu_src_a`=1, `alu_src_b`=0. `aluop`: 3 for sll, 4 for srl, 2 for add. → ALUWB.
  - ALUWB: `reg_write`=1, `reg_dst`=1, `retire`=1 → FETCH.
  - ADDIEX: `alu_src_a`=1, `alu_src_b`=2, `aluop`=2 → ADDIWB.
  - ADDIWB: `reg_write`=1, `reg_dst`=0, `retire`=1 → FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=0, `aluop`=6, `pc_src`=1, `pc_en`=`zero`, `retire`=1 → FETCH.
  - JUMP: `pc_src`=2, `pc_en`=1, `retire`=1 → FETCH.
  - FAULT: `fault`=1, `fault_code` held. Remains in FAULT until reset.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle with `mem_req`=1 and `mem_ack`=0.
  - If the counter equals TIMEOUT-1 with no ack, the next state is FAULT with `fault_code`=1.
  - An ack in that same last cycle is accepted.
- `mem_ack` while `mem_req`=0 is ignored.
- `opcode` and `funct` must be stable from DECODE through instruction completion.

## Timing
- Reset: state = START; counter = 0; `fault_code` = 0; all outputs 0 while `rst_n`=0.
- First `mem_req` is asserted in the second cycle after `rst_n` deasserts.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi/addiu 4, beq 3, j 3. Each wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to START; `mem_req` drops asynchronously.

## Configuration
- MCYCLE_JUMP_EN:
  - Defined: opcode 0x02 decodes to JUMP.
  - Undefined: JUMP state is absent and opcode 0x02 → FAULT with `fault_code`=2.

## Test plan
- Release reset; `mem_ack` tied 1; instruction = addi (0x08) → states FETCH, DECODE, ADDIEX, ADDIWB. `aluop`=2 in ADDIEX. `reg_write`=1 and `retire`=1 in cycle 4 after FETCH entry.
- lw with 3 wait cycles on the data access → MEMRD lasts 4 cycles with `iord`=1. `mem_to_reg`=1 in MEMWB. Total 8 cycles.
- R-type with funct 0x00, 0x02 and 0x20 → `aluop` in EXEC is 3, 4 and 2 respectively. `reg_dst`=1 in ALUWB.
- beq with `zero`=1, then beq with `zero`=0 → `pc_en`=1 with `pc_src`=1 in the first case; `pc_en`=0 in the second. Both take 3 cycles.
- TIMEOUT=4, `mem_ack` held 0 in FETCH → `mem_req` high 4 cycles, then FAULT with `fault`=1, `fault_code`=1, held until reset. Repeat with ack in the 4th cycle → DECODE, no fault.
- Opcode 0x02 with macro undefined → FAULT, `fault_code`=2. With macro defined → JUMP with `pc_src`=2, `pc_en`=1, `retire`=1.
